// File: rtl/cmd_point_stack_pkg.sv
// rtl/cmd_point_stack_pkg.sv - opcode encodings shared by the pointer and the command decoder
package cmd_point_stack_pkg;

    localparam logic [2:0] NUL  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] SJF  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] SJB  = 3'b100;
    localparam logic [2:0] RET  = 3'b101;
    localparam logic [2:0] HOLD = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

endpackage

// File: rtl/cmd_point_stack_cmd_stack.sv
// rtl/cmd_point_stack_cmd_stack.sv - return-address LIFO with level counter
module cmd_stack #(
    parameter int BUS_WIDTH   = 32,
    parameter int STACK_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [BUS_WIDTH-1:0]                 din,
    output logic [BUS_WIDTH-1:0]                 dout,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     level,
    output logic                                 full,
    output logic                                 empty
);

    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = $clog2(STACK_DEPTH);

    logic [BUS_WIDTH-1:0] mem [STACK_DEPTH];
    logic [LW-1:0]        top_lvl;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (level == LW'(STACK_DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty & ~push;
    assign top_lvl = level - LW'(1);

    // Top entry is read combinationally so RET completes in the accepting cycle.
    assign dout = empty ? '0 : mem[top_lvl[IW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[level[IW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else if (do_push) begin
            level <= level + LW'(1);
        end else if (do_pop) begin
            level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/cmd_point_stack.sv
// rtl/cmd_point_stack.sv - command-address pointer with handshake, CALL/RET stack and sticky faults
module cmd_point_stack
    import cmd_point_stack_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int STACK_DEPTH = 8,
    parameter int STEP        = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [2:0]                           opcode,
    input  logic [BUS_WIDTH-1:0]                 addr_to,
    output logic [BUS_WIDTH-1:0]                 addr_point,
    output logic                                 ready,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_level,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam logic [BUS_WIDTH-1:0] STEP_W = BUS_WIDTH'(STEP);

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [BUS_WIDTH-1:0] top;
    logic [BUS_WIDTH-1:0] next_seq;

    assign cmd_ready = ready;
    assign accept    = cmd_valid & ready;
    assign next_seq  = addr_point + STEP_W;
    assign push      = accept && (opcode == CALL);
    assign pop       = accept && (opcode == RET);

    cmd_stack #(
        .BUS_WIDTH   (BUS_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (next_seq),
        .dout  (top),
        .level (stack_level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_point <= '0;
            ready      <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (accept) begin
                case (opcode)
                    NUL:  addr_point <= next_seq;
                    JMP:  addr_point <= addr_to;
                    SJF:  addr_point <= addr_point + addr_to;
                    SJB:  addr_point <= addr_point - addr_to;
                    CALL: begin
                        if (full) overflow <= 1'b1;
                        else      addr_point <= addr_to;
                    end
                    RET: begin
                        if (empty) underflow <= 1'b1;
                        else       addr_point <= top;
                    end
                    CLR: begin
                        overflow   <= 1'b0;
                        underflow  <= 1'b0;
                        addr_point <= next_seq;
                    end
                    default: addr_point <= addr_point;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_point_stack.sv
// tb/tb_cmd_point_stack.sv - directed vector bench for cmd_point_stack
module tb_cmd_point_stack;
    import cmd_point_stack_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  opcode;
    logic [31:0] addr_to;
    logic [31:0] addr_point;
    logic        ready;
    logic [3:0]  stack_level;
    logic        overflow;
    logic        underflow;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] ep;
        logic [3:0]  el;
        logic        eo;
        logic        eu;
    } vec_t;

    vec_t vecs [18];

    cmd_point_stack #(
        .BUS_WIDTH   (32),
        .STACK_DEPTH (8),
        .STEP        (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .opcode      (opcode),
        .addr_to     (addr_to),
        .addr_point  (addr_point),
        .ready       (ready),
        .stack_level (stack_level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a);
        cmd_valid = v;
        opcode    = op;
        addr_to   = a;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] ep, input logic [3:0] el,
                               input logic eo, input logic eu);
        check({tag, ".addr_point"}, addr_point, ep);
        check({tag, ".stack_level"}, 32'(stack_level), 32'(el));
        check({tag, ".overflow"}, 32'(overflow), 32'(eo));
        check({tag, ".underflow"}, 32'(underflow), 32'(eu));
    endtask

    initial begin
        vecs[0]  = '{1'b1, NUL,  32'h0,        32'h1,        4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, NUL,  32'h0,        32'h2,        4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, JMP,  32'h100,      32'h100,      4'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, SJF,  32'h10,       32'h110,      4'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, SJB,  32'h20,       32'hF0,       4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, JMP,  32'h999,      32'hF0,       4'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, JMP,  32'h40,       32'h40,       4'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, CALL, 32'h200,      32'h200,      4'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, CALL, 32'h300,      32'h300,      4'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, RET,  32'h0,        32'h201,      4'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, RET,  32'h0,        32'h41,       4'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, RET,  32'h0,        32'h41,       4'd0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, JMP,  32'h5,        32'h5,        4'd0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, CLR,  32'h0,        32'h6,        4'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, JMP,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, NUL,  32'h0,        32'h0,        4'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, SJB,  32'h1,        32'hFFFFFFFF, 4'd0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, HOLD, 32'h1234,     32'hFFFFFFFF, 4'd0, 1'b0, 1'b0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        opcode    = NUL;
        addr_to   = '0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst%0d.ready", i), 32'(ready), 32'd0);
            check($sformatf("rst%0d.cmd_ready", i), 32'(cmd_ready), 32'd0);
        end
        check_state("rst", 32'h0, 4'd0, 1'b0, 1'b0);

        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rel.ready", 32'(ready), 32'd1);
        check("rel.cmd_ready", 32'(cmd_ready), 32'd1);
        check("rel.addr_point", addr_point, 32'h0);
        step(1'b0, NUL, 32'h0);
        check("idle.addr_point", addr_point, 32'h0);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].v, vecs[i].op, vecs[i].a);
            check_state($sformatf("vec%0d", i), vecs[i].ep, vecs[i].el, vecs[i].eo, vecs[i].eu);
        end

        // Nine CALLs into a depth-8 stack: last one overflows and leaves P alone.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, CALL, 32'h1000 + 32'(i));
            if (i < 8) check_state($sformatf("call%0d", i), 32'h1000 + 32'(i), 4'(i + 1), 1'b0, 1'b0);
            else       check_state("call8", 32'h1007, 4'd8, 1'b1, 1'b0);
        end
        step(1'b1, CLR, 32'h0);
        check_state("clr_ov", 32'h1008, 4'd8, 1'b0, 1'b0);
        step(1'b1, RET, 32'h0);
        check_state("ret_full", 32'h1007, 4'd7, 1'b0, 1'b0);

        opcode  = 3'bxxx;
        addr_to = 32'hxxxxxxxx;
        step(1'b0, 3'bxxx, 32'hxxxxxxxx);
        check_state("xop", 32'h1007, 4'd7, 1'b0, 1'b0);

        reset = 1'b1;
        step(1'b1, CALL, 32'h777);
        check_state("rst_call", 32'h0, 4'd0, 1'b0, 1'b0);
        check("rst_call.ready", 32'(ready), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_call.rel_ready", 32'(ready), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
